// File: rtl/lift_pkg.sv
// Shared types and helpers for the N-floor lift controller.
//   state_t : controller states (IDLE, MOVE, DOOR, HALT)
//   UP/DOWN : travel direction encoding
//   fw()    : width needed to index n items, never less than 1 bit
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  function automatic int fw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lift_req_scan.sv
// Request scanner: classifies the effective request set relative to a floor.
//   req_eff : per-floor request bits
//   pos     : reference floor
//   hit     : request at pos
//   above   : any request at a floor > pos
//   below   : any request at a floor < pos
// Purely combinational. A pos beyond the top floor simply yields below-only.
module lift_req_scan
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 8
) (
  input  logic [NUM_FLOORS-1:0]      req_eff,
  input  logic [fw(NUM_FLOORS)-1:0]  pos,
  output logic                       hit,
  output logic                       above,
  output logic                       below
);

  always_comb begin
    hit   = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req_eff[i]) begin
        if (i == int'(pos))     hit   = 1'b1;
        else if (i > int'(pos)) above = 1'b1;
        else                    below = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lift_ctrl_n.sv
// N-floor lift controller with SCAN ordering.
//   clk, rst     : clock, synchronous active-high reset
//   call_req     : per-floor call inputs, latched into pending
//   estop        : emergency stop (level); gates motion/door outputs at once
//   cur_floor    : current floor
//   motor_up/down: car travelling up / down
//   door_open    : door open at cur_floor
//   pending      : latched, not yet served calls
//   halted       : controller in HALT
//   served_count : saturating count of door openings
module lift_ctrl_n
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_FLOORS-1:0]     call_req,
  input  logic                      estop,
  output logic [fw(NUM_FLOORS)-1:0] cur_floor,
  output logic                      motor_up,
  output logic                      motor_down,
  output logic                      door_open,
  output logic [NUM_FLOORS-1:0]     pending,
  output logic                      halted,
  output logic [CNT_W-1:0]          served_count
);

  localparam int FW = fw(NUM_FLOORS);
  localparam int MW = fw(MOVE_CYCLES);
  localparam int DW = fw(DOOR_CYCLES);

  state_t                state, state_nxt;
  logic                  dir, dir_nxt;
  logic [FW-1:0]         floor_nxt, step_floor;
  logic                  step;
  logic [MW-1:0]         move_cnt;
  logic [DW-1:0]         door_cnt;
  logic [NUM_FLOORS-1:0] req_eff, clr_mask;
  logic                  hit, above, below;
  logic                  hit_n, above_n, below_n;
  logic                  ahead, ahead_n, call_here, door_entry;

  assign req_eff    = pending | call_req;
  assign call_here  = call_req[cur_floor];
  // Candidate floor after one step in the current direction; only used when
  // a request lies ahead, so the wrap at the shaft ends is never taken.
  assign step_floor = dir ? cur_floor + FW'(1) : cur_floor - FW'(1);
  assign ahead      = dir ? above   : below;
  assign ahead_n    = dir ? above_n : below_n;

  lift_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_cur (
    .req_eff (req_eff),
    .pos     (cur_floor),
    .hit     (hit),
    .above   (above),
    .below   (below)
  );

  // Same scan seen from the floor the car is about to arrive at.
  lift_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_nxt (
    .req_eff (req_eff),
    .pos     (step_floor),
    .hit     (hit_n),
    .above   (above_n),
    .below   (below_n)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic (also resolves direction and the floor step)
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    floor_nxt = cur_floor;
    step      = 1'b0;
    if (estop) begin
      state_nxt = HALT;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state_nxt = DOOR;
          end else if (above && (dir == UP || !below)) begin
            state_nxt = MOVE;
            dir_nxt   = UP;
          end else if (below) begin
            state_nxt = MOVE;
            dir_nxt   = DOWN;
          end
        end
        MOVE: begin
          if (move_cnt == '0) begin
            if (ahead) begin
              step      = 1'b1;
              floor_nxt = step_floor;
              if (hit_n)        state_nxt = DOOR;
              else if (ahead_n) state_nxt = MOVE;
              else              state_nxt = IDLE;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DOOR: begin
          // A fresh call here keeps the door open; otherwise close at 0.
          if (!call_here && door_cnt == '0) state_nxt = IDLE;
        end
        HALT:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: registered state, with estop gating motion and door at once
  always_comb begin
    motor_up   = 1'b0;
    motor_down = 1'b0;
    door_open  = 1'b0;
    halted     = (state == HALT);
    if (!estop) begin
      motor_up   = (state == MOVE) && (dir == UP);
      motor_down = (state == MOVE) && (dir == DOWN);
      door_open  = (state == DOOR);
    end
  end

  assign door_entry = (state_nxt == DOOR) && (state != DOOR);
  // The floor being served never latches a call while its door is open.
  assign clr_mask   = (state_nxt == DOOR || state == DOOR) ?
                      (NUM_FLOORS'(1) << floor_nxt) : '0;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_floor    <= '0;
      dir          <= UP;
      pending      <= '0;
      move_cnt     <= MW'(MOVE_CYCLES - 1);
      door_cnt     <= '0;
      served_count <= '0;
    end else begin
      cur_floor <= floor_nxt;
      dir       <= dir_nxt;
      pending   <= req_eff & ~clr_mask;

      // Count only while travel continues uninterrupted; any exit from MOVE
      // (arrival, halt) leaves a full floor time for the next departure.
      if (state == MOVE && state_nxt == MOVE && !step)
        move_cnt <= move_cnt - 1'b1;
      else
        move_cnt <= MW'(MOVE_CYCLES - 1);

      if (state_nxt == DOOR) begin
        if (door_entry || call_here) door_cnt <= DW'(DOOR_CYCLES - 1);
        else                         door_cnt <= door_cnt - 1'b1;
      end else begin
        door_cnt <= '0;
      end

      if (door_entry && served_count != '1)
        served_count <= served_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lift_ctrl_n.sv
module tb_lift_ctrl_n;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] call_req;
  logic         estop;
  logic [2:0]   cur_floor;
  logic         motor_up, motor_down, door_open, halted;
  logic [N-1:0] pending;
  logic [15:0]  served_count;

  lift_ctrl_n #(
    .NUM_FLOORS(N), .MOVE_CYCLES(3), .DOOR_CYCLES(4), .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_req     (call_req),
    .estop        (estop),
    .cur_floor    (cur_floor),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .pending      (pending),
    .halted       (halted),
    .served_count (served_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    c;
    string tag;
    int    fl;
    bit    mu, md, dr, hl;
    int    pend;
    int    srv;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output snapshot for cycle (now + dc).
  task automatic ex(input int dc, input string tag, input int fl,
                    input bit mu, input bit md, input bit dr, input bit hl,
                    input int pend, input int srv);
    exp_t e;
    e.c = cyc + dc; e.tag = tag; e.fl = fl;
    e.mu = mu; e.md = md; e.dr = dr; e.hl = hl;
    e.pend = pend; e.srv = srv;
    q.push_back(e);
  endtask

  // Monitor: mid-cycle, pop every expectation due now and compare.
  always @(negedge clk) begin
    logic ok;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c <= cyc) begin
        checks++;
        ok = (q[i].c == cyc) &&
             (int'(cur_floor) == q[i].fl) && (motor_up === q[i].mu) &&
             (motor_down === q[i].md) && (door_open === q[i].dr) &&
             (halted === q[i].hl) && (int'(pending) == q[i].pend) &&
             (int'(served_count) == q[i].srv);
        if (ok !== 1'b1) begin
          errors++;
          $display("FAIL %s @cyc%0d: got fl=%0d up=%b dn=%b door=%b halt=%b pend=%h srv=%0d, want fl=%0d up=%b dn=%b door=%b halt=%b pend=%h srv=%0d",
                   q[i].tag, q[i].c, cur_floor, motor_up, motor_down, door_open,
                   halted, pending, served_count, q[i].fl, q[i].mu, q[i].md,
                   q[i].dr, q[i].hl, q[i].pend, q[i].srv);
        end
        q.delete(i);
      end
    end
    if (done) begin
      foreach (q[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc%0d never checked", q[i].tag, q[i].c);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; call_req = '0; estop = 1'b0;
    repeat (3) tick();

    // 1: reset state, then 20 quiet cycles
    rst = 1'b0;
    for (int i = 0; i < 20; i++) ex(i, "idle", 0, 0, 0, 0, 0, 8'h00, 0);
    repeat (20) tick();

    // 2: call at the current floor -> door 4 cycles from next cycle
    ex(0, "call0_pre", 0, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) ex(i, "call0_door", 0, 0, 0, 1, 0, 8'h00, 1);
    ex(5, "call0_close", 0, 0, 0, 0, 0, 8'h00, 1);
    call_req = 8'h01; tick(); call_req = '0;
    repeat (5) tick();

    // 3: floor 0 -> 3
    ex(0, "up3_pre", 0, 0, 0, 0, 0, 8'h00, 1);
    for (int i = 1; i <= 9; i++) ex(i, "up3_move", (i - 1) / 3, 1, 0, 0, 0, 8'h08, 1);
    for (int i = 10; i <= 13; i++) ex(i, "up3_door", 3, 0, 0, 1, 0, 8'h00, 2);
    ex(14, "up3_close", 3, 0, 0, 0, 0, 8'h00, 2);
    call_req = 8'h08; tick(); call_req = '0;
    repeat (14) tick();

    // 4: at 3 heading up, calls for 5 and 1 -> 5 first, then reverse to 1
    ex(0, "scan_pre", 3, 0, 0, 0, 0, 8'h00, 2);
    for (int i = 1; i <= 6; i++) ex(i, "scan_up", 3 + (i - 1) / 3, 1, 0, 0, 0, 8'h22, 2);
    for (int i = 7; i <= 10; i++) ex(i, "scan_door5", 5, 0, 0, 1, 0, 8'h02, 3);
    ex(11, "scan_idle5", 5, 0, 0, 0, 0, 8'h02, 3);
    for (int i = 12; i <= 23; i++) ex(i, "scan_down", 5 - (i - 12) / 3, 0, 1, 0, 0, 8'h02, 3);
    for (int i = 24; i <= 27; i++) ex(i, "scan_door1", 1, 0, 0, 1, 0, 8'h00, 4);
    ex(28, "scan_idle1", 1, 0, 0, 0, 0, 8'h00, 4);
    call_req = 8'h22; tick(); call_req = '0;
    repeat (28) tick();

    // 5: estop mid-move at move_cnt=1, call during HALT, release
    ex(0,  "estop_pre",    1, 0, 0, 0, 0, 8'h00, 4);
    ex(1,  "estop_move",   1, 1, 0, 0, 0, 8'h10, 4);
    ex(2,  "estop_gate",   1, 0, 0, 0, 0, 8'h10, 4);
    ex(3,  "estop_halt",   1, 0, 0, 0, 1, 8'h10, 4);
    ex(4,  "estop_latch",  1, 0, 0, 0, 1, 8'h11, 4);
    ex(5,  "estop_rel",    1, 0, 0, 0, 1, 8'h11, 4);
    ex(6,  "estop_idle",   1, 0, 0, 0, 0, 8'h11, 4);
    for (int i = 7; i <= 9; i++) ex(i, "estop_remove", 1, 1, 0, 0, 0, 8'h11, 4);
    ex(10, "estop_step",   2, 1, 0, 0, 0, 8'h11, 4);
    ex(16, "estop_door4",  4, 0, 0, 1, 0, 8'h01, 5);
    ex(21, "estop_down",   4, 0, 1, 0, 0, 8'h01, 5);
    ex(33, "estop_door0",  0, 0, 0, 1, 0, 8'h00, 6);
    ex(37, "estop_idle0",  0, 0, 0, 0, 0, 8'h00, 6);
    call_req = 8'h10; tick();
    call_req = '0;    tick();
    estop = 1'b1;     tick();
    call_req = 8'h01; tick();
    call_req = '0;    tick();
    estop = 1'b0;
    repeat (33) tick();

    // 6a: repeated call at the open floor restarts the dwell, counts once
    ex(0, "redoor_pre", 0, 0, 0, 0, 0, 8'h00, 6);
    for (int i = 1; i <= 6; i++) ex(i, "redoor_door", 0, 0, 0, 1, 0, 8'h00, 7);
    ex(7, "redoor_close", 0, 0, 0, 0, 0, 8'h00, 7);
    call_req = 8'h01; tick();
    call_req = '0;    tick();
    call_req = 8'h01; tick();
    call_req = '0;
    repeat (6) tick();

    // 6b: reset mid-move
    ex(3, "rst_move0", 0, 1, 0, 0, 0, 8'h80, 7);
    ex(5, "rst_move1", 1, 1, 0, 0, 0, 8'h80, 7);
    ex(6, "rst_cleared", 0, 0, 0, 0, 0, 8'h00, 0);
    ex(7, "rst_idle", 0, 0, 0, 0, 0, 8'h00, 0);
    call_req = 8'h80; tick();
    call_req = '0;
    repeat (4) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (3) tick();

    done = 1'b1;
  end

endmodule
